// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: bus widths, MIPS opcode/funct
// constants, ALU operation/result-class encodings and the instruction decoder.
package id_stage_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 8;
    localparam int ALU_SEL_W  = 3;

    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [ALU_OP_W-1:0] {
        EXE_NOP_OP  = 8'h00,
        EXE_SRL_OP  = 8'h02,
        EXE_SRA_OP  = 8'h03,
        EXE_ADDU_OP = 8'h21,
        EXE_SUBU_OP = 8'h23,
        EXE_AND_OP  = 8'h24,
        EXE_OR_OP   = 8'h25,
        EXE_XOR_OP  = 8'h26,
        EXE_NOR_OP  = 8'h27,
        EXE_SLT_OP  = 8'h2A,
        EXE_SLL_OP  = 8'h7C,
        EXE_LW_OP   = 8'hE3,
        EXE_SW_OP   = 8'hEB
    } alu_op_e;

    typedef enum logic [ALU_SEL_W-1:0] {
        EXE_RES_NOP        = 3'd0,
        EXE_RES_LOGIC      = 3'd1,
        EXE_RES_SHIFT      = 3'd2,
        EXE_RES_ARITH      = 3'd4,
        EXE_RES_LOAD_STORE = 3'd7
    } alu_sel_e;

    // Decoder result: imm1/imm2 are the operand values used when a port is not read.
    typedef struct packed {
        alu_op_e                aluop;
        alu_sel_e               alusel;
        logic                   re1;
        logic                   re2;
        logic [REG_W-1:0]       imm1;
        logic [REG_W-1:0]       imm2;
        logic [REG_ADDR_W-1:0]  wd;
        logic                   wreg;
        logic                   ri;
    } decode_t;

    // Contents of the ID/EX pipeline register.
    typedef struct packed {
        logic                   valid;
        logic [REG_W-1:0]       pc;
        alu_op_e                aluop;
        alu_sel_e               alusel;
        logic [REG_W-1:0]       reg1;
        logic [REG_W-1:0]       reg2;
        logic [REG_ADDR_W-1:0]  wd;
        logic                   wreg;
        logic                   ri;
    } id_ex_t;

    function automatic decode_t decode(input logic [REG_W-1:0] inst);
        decode_t         d;
        logic [5:0]      op;
        logic [5:0]      funct;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      sa;
        logic [15:0]     imm;
        op    = inst[31:26];
        rt    = inst[20:16];
        rd    = inst[15:11];
        sa    = inst[10:6];
        funct = inst[5:0];
        imm   = inst[15:0];

        d        = '0;
        d.aluop  = EXE_NOP_OP;
        d.alusel = EXE_RES_NOP;

        case (op)
            OP_SPECIAL: begin
                d.wd   = rd;
                d.wreg = 1'b1;
                d.re1  = 1'b1;
                d.re2  = 1'b1;
                case (funct)
                    FN_AND:  begin d.aluop = EXE_AND_OP;  d.alusel = EXE_RES_LOGIC; end
                    FN_OR:   begin d.aluop = EXE_OR_OP;   d.alusel = EXE_RES_LOGIC; end
                    FN_XOR:  begin d.aluop = EXE_XOR_OP;  d.alusel = EXE_RES_LOGIC; end
                    FN_NOR:  begin d.aluop = EXE_NOR_OP;  d.alusel = EXE_RES_LOGIC; end
                    FN_ADDU: begin d.aluop = EXE_ADDU_OP; d.alusel = EXE_RES_ARITH; end
                    FN_SUBU: begin d.aluop = EXE_SUBU_OP; d.alusel = EXE_RES_ARITH; end
                    FN_SLT:  begin d.aluop = EXE_SLT_OP;  d.alusel = EXE_RES_ARITH; end
                    // Shifts take the shift amount in operand 1 and rt in operand 2.
                    FN_SLL:  begin d.aluop = EXE_SLL_OP; d.alusel = EXE_RES_SHIFT; d.re1 = 1'b0; d.imm1 = {27'b0, sa}; end
                    FN_SRL:  begin d.aluop = EXE_SRL_OP; d.alusel = EXE_RES_SHIFT; d.re1 = 1'b0; d.imm1 = {27'b0, sa}; end
                    FN_SRA:  begin d.aluop = EXE_SRA_OP; d.alusel = EXE_RES_SHIFT; d.re1 = 1'b0; d.imm1 = {27'b0, sa}; end
                    default: begin d.wd = '0; d.wreg = 1'b0; d.re1 = 1'b0; d.re2 = 1'b0; d.ri = 1'b1; end
                endcase
            end
            OP_ANDI: begin
                d.aluop = EXE_AND_OP;  d.alusel = EXE_RES_LOGIC;
                d.re1 = 1'b1; d.imm2 = {16'b0, imm}; d.wd = rt; d.wreg = 1'b1;
            end
            OP_ORI: begin
                d.aluop = EXE_OR_OP;   d.alusel = EXE_RES_LOGIC;
                d.re1 = 1'b1; d.imm2 = {16'b0, imm}; d.wd = rt; d.wreg = 1'b1;
            end
            OP_XORI: begin
                d.aluop = EXE_XOR_OP;  d.alusel = EXE_RES_LOGIC;
                d.re1 = 1'b1; d.imm2 = {16'b0, imm}; d.wd = rt; d.wreg = 1'b1;
            end
            // LUI is an OR of zero with the shifted immediate; rs is ignored.
            OP_LUI: begin
                d.aluop = EXE_OR_OP;   d.alusel = EXE_RES_LOGIC;
                d.imm2 = {imm, 16'h0}; d.wd = rt; d.wreg = 1'b1;
            end
            OP_ADDIU: begin
                d.aluop = EXE_ADDU_OP; d.alusel = EXE_RES_ARITH;
                d.re1 = 1'b1; d.imm2 = {{16{imm[15]}}, imm}; d.wd = rt; d.wreg = 1'b1;
            end
            OP_SLTI: begin
                d.aluop = EXE_SLT_OP;  d.alusel = EXE_RES_ARITH;
                d.re1 = 1'b1; d.imm2 = {{16{imm[15]}}, imm}; d.wd = rt; d.wreg = 1'b1;
            end
            OP_LW: begin
                d.aluop = EXE_LW_OP;   d.alusel = EXE_RES_LOAD_STORE;
                d.re1 = 1'b1; d.imm2 = {{16{imm[15]}}, imm}; d.wd = rt; d.wreg = 1'b1;
            end
            // SW reads the base (rs) and the store data (rt); it writes no register.
            OP_SW: begin
                d.aluop = EXE_SW_OP;   d.alusel = EXE_RES_LOAD_STORE;
                d.re1 = 1'b1; d.re2 = 1'b1; d.imm2 = {{16{imm[15]}}, imm};
            end
            default: d.ri = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_stage_operand_mux.sv
// Per-port operand selection: immediate, hardwired zero, EX/MEM forwarding or
// regfile data, plus the load-use hazard flag for this port.
module id_stage_operand_mux
    import id_stage_pkg::*;
(
    input  logic                  read,
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [REG_W-1:0]      rf_data,
    input  logic [REG_W-1:0]      imm,
    input  logic                  ex_wreg,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic [REG_W-1:0]      ex_wdata,
    input  logic                  ex_is_load,
    input  logic                  mem_wreg,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic [REG_W-1:0]      mem_wdata,
    output logic [REG_W-1:0]      data,
    output logic                  load_hazard
);

    // Pick the freshest value: the younger EX result shadows the MEM result.
    always_comb begin
        // NOTE: assigning a default first guarantees every path drives data, so no latch is inferred.
        data = rf_data;
        if (!read) begin
            data = imm;
        end else if (addr == '0) begin
            data = ZERO_WORD;
        end else if (ex_wreg && (ex_wd == addr)) begin
            data = ex_wdata;
        end else if (mem_wreg && (mem_wd == addr)) begin
            data = mem_wdata;
        end
    end

    // A load in EX has no data yet, so a matching read must wait one cycle.
    assign load_hazard = read && (addr != '0) && ex_wreg && ex_is_load && (ex_wd == addr);

endmodule

// File: rtl/id_stage.sv
// MIPS32 instruction-decode stage: decodes IF/ID, drives regfile reads,
// resolves forwarded operands, detects load-use hazards and loads ID/EX.
module id_stage
    import id_stage_pkg::*;
#(
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_inst_i,
    input  logic        if_valid_i,
    output logic        reg1_read_o,
    output logic [4:0]  reg1_addr_o,
    input  logic [31:0] reg1_data_i,
    output logic        reg2_read_o,
    output logic [4:0]  reg2_addr_o,
    input  logic [31:0] reg2_data_i,
    input  logic        ex_wreg_i,
    input  logic [4:0]  ex_wd_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        ex_is_load_i,
    input  logic        mem_wreg_i,
    input  logic [4:0]  mem_wd_i,
    input  logic [31:0] mem_wdata_i,
    output logic        stallreq_o,
    output logic        ex_valid_o,
    output logic [31:0] ex_pc_o,
    output logic [7:0]  ex_aluop_o,
    output logic [2:0]  ex_alusel_o,
    output logic [31:0] ex_reg1_o,
    output logic [31:0] ex_reg2_o,
    output logic [4:0]  ex_wd_o,
    output logic        ex_wreg_o,
    output logic        ex_ri_o
);

    localparam id_ex_t BUBBLE = '{
        valid:  1'b0,
        pc:     RST_PC,
        aluop:  EXE_NOP_OP,
        alusel: EXE_RES_NOP,
        reg1:   ZERO_WORD,
        reg2:   ZERO_WORD,
        wd:     '0,
        wreg:   1'b0,
        ri:     1'b0
    };

    decode_t          dec;
    logic [REG_W-1:0] op1;
    logic [REG_W-1:0] op2;
    logic             hazard1;
    logic             hazard2;
    id_ex_t           id_ex_d;
    id_ex_t           id_ex_q;

    // Decode the instruction currently held in IF/ID.
    always_comb begin
        dec = decode(if_inst_i);
    end

    // Unused ports present address 0 so the regfile sees no spurious reads.
    assign reg1_read_o = dec.re1;
    assign reg1_addr_o = dec.re1 ? if_inst_i[25:21] : '0;
    assign reg2_read_o = dec.re2;
    assign reg2_addr_o = dec.re2 ? if_inst_i[20:16] : '0;

    id_stage_operand_mux u_operand_mux1 (
        .read        (reg1_read_o),
        .addr        (reg1_addr_o),
        .rf_data     (reg1_data_i),
        .imm         (dec.imm1),
        .ex_wreg     (ex_wreg_i),
        .ex_wd       (ex_wd_i),
        .ex_wdata    (ex_wdata_i),
        .ex_is_load  (ex_is_load_i),
        .mem_wreg    (mem_wreg_i),
        .mem_wd      (mem_wd_i),
        .mem_wdata   (mem_wdata_i),
        .data        (op1),
        .load_hazard (hazard1)
    );

    id_stage_operand_mux u_operand_mux2 (
        .read        (reg2_read_o),
        .addr        (reg2_addr_o),
        .rf_data     (reg2_data_i),
        .imm         (dec.imm2),
        .ex_wreg     (ex_wreg_i),
        .ex_wd       (ex_wd_i),
        .ex_wdata    (ex_wdata_i),
        .ex_is_load  (ex_is_load_i),
        .mem_wreg    (mem_wreg_i),
        .mem_wd      (mem_wd_i),
        .mem_wdata   (mem_wdata_i),
        .data        (op2),
        .load_hazard (hazard2)
    );

    // Stall request only for a real instruction, and never while in reset.
    assign stallreq_o = !rst && if_valid_i && (hazard1 || hazard2);

    // Assemble the value ID/EX takes when a real instruction advances.
    always_comb begin
        id_ex_d        = BUBBLE;
        id_ex_d.valid  = 1'b1;
        id_ex_d.pc     = if_pc_i;
        id_ex_d.aluop  = dec.aluop;
        id_ex_d.alusel = dec.alusel;
        id_ex_d.reg1   = op1;
        id_ex_d.reg2   = op2;
        id_ex_d.wd     = dec.wd;
        id_ex_d.wreg   = dec.wreg;
        id_ex_d.ri     = dec.ri;
    end

    // ID/EX register: flush beats stall, stall beats a hazard bubble.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            id_ex_q <= BUBBLE;
        end else if (flush_i) begin
            id_ex_q <= BUBBLE;
        end else if (stall_i) begin
            id_ex_q <= id_ex_q;
        end else if (stallreq_o || !if_valid_i) begin
            id_ex_q <= BUBBLE;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ex_valid_o  = id_ex_q.valid;
    assign ex_pc_o     = id_ex_q.pc;
    assign ex_aluop_o  = id_ex_q.aluop;
    assign ex_alusel_o = id_ex_q.alusel;
    assign ex_reg1_o   = id_ex_q.reg1;
    assign ex_reg2_o   = id_ex_q.reg2;
    assign ex_wd_o     = id_ex_q.wd;
    assign ex_wreg_o   = id_ex_q.wreg;
    assign ex_ri_o     = id_ex_q.ri;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: expected ID/EX contents are queued when an
// instruction is presented and compared after the following clock edge.
module tb_id_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i;
    logic [31:0] if_pc_i, if_inst_i;
    logic        if_valid_i;
    logic        reg1_read_o, reg2_read_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        stallreq_o;
    logic        ex_valid_o, ex_wreg_o, ex_ri_o;
    logic [31:0] ex_pc_o, ex_reg1_o, ex_reg2_o;
    logic [7:0]  ex_aluop_o;
    logic [2:0]  ex_alusel_o;
    logic [4:0]  ex_wd_o;

    id_stage #(.RST_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .if_pc_i      (if_pc_i),
        .if_inst_i    (if_inst_i),
        .if_valid_i   (if_valid_i),
        .reg1_read_o  (reg1_read_o),
        .reg1_addr_o  (reg1_addr_o),
        .reg1_data_i  (reg1_data_i),
        .reg2_read_o  (reg2_read_o),
        .reg2_addr_o  (reg2_addr_o),
        .reg2_data_i  (reg2_data_i),
        .ex_wreg_i    (ex_wreg_i),
        .ex_wd_i      (ex_wd_i),
        .ex_wdata_i   (ex_wdata_i),
        .ex_is_load_i (ex_is_load_i),
        .mem_wreg_i   (mem_wreg_i),
        .mem_wd_i     (mem_wd_i),
        .mem_wdata_i  (mem_wdata_i),
        .stallreq_o   (stallreq_o),
        .ex_valid_o   (ex_valid_o),
        .ex_pc_o      (ex_pc_o),
        .ex_aluop_o   (ex_aluop_o),
        .ex_alusel_o  (ex_alusel_o),
        .ex_reg1_o    (ex_reg1_o),
        .ex_reg2_o    (ex_reg2_o),
        .ex_wd_o      (ex_wd_o),
        .ex_wreg_o    (ex_wreg_o),
        .ex_ri_o      (ex_ri_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic        ri;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [7:0] op,
                                input logic [2:0] sel, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [4:0] wd, input logic wreg, input logic ri);
        exp_t e;
        e.valid = v; e.pc = pc; e.aluop = op; e.alusel = sel;
        e.reg1 = r1; e.reg2 = r2; e.wd = wd; e.wreg = wreg; e.ri = ri;
        return e;
    endfunction

    function automatic exp_t bubble();
        return mk(1'b0, RST_PC, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sa,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic compare_out(input string name, input exp_t e);
        check({name, ".valid"},  ex_valid_o,  e.valid);
        check({name, ".pc"},     ex_pc_o,     e.pc);
        check({name, ".aluop"},  ex_aluop_o,  e.aluop);
        check({name, ".alusel"}, ex_alusel_o, e.alusel);
        check({name, ".reg1"},   ex_reg1_o,   e.reg1);
        check({name, ".reg2"},   ex_reg2_o,   e.reg2);
        check({name, ".wd"},     ex_wd_o,     e.wd);
        check({name, ".wreg"},   ex_wreg_o,   e.wreg);
        check({name, ".ri"},     ex_ri_o,     e.ri);
    endtask

    // Advance one cycle and compare ID/EX against the oldest queued expectation.
    task automatic tick(input string name);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty got 0 entries expected 1", name);
            $fatal(1);
        end
        compare_out(name, sb.pop_front());
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] ewd, input logic [31:0] edata,
                           input logic eload, input logic mw, input logic [4:0] mwd,
                           input logic [31:0] mdata);
        ex_wreg_i = ew;  ex_wd_i = ewd;  ex_wdata_i = edata; ex_is_load_i = eload;
        mem_wreg_i = mw; mem_wd_i = mwd; mem_wdata_i = mdata;
    endtask

    task automatic set_inst(input logic [31:0] inst, input logic [31:0] pc, input logic v);
        if_inst_i = inst; if_pc_i = pc; if_valid_i = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        reg1_data_i = '0; reg2_data_i = '0;
        // Hazard conditions present during reset: stall request must stay low.
        set_fwd(1'b1, 5'd4, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        set_inst(r_type(5'd4, 5'd4, 5'd5, 5'd0, 6'h21), 32'h0000_00F0, 1'b1);
        #12;
        compare_out("reset", bubble());
        check("reset.stallreq", stallreq_o, 1'b0);
        @(posedge clk);
        #1;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        rst = 1'b0;

        // ORI $1,$0,0x8000: zero-extended immediate, only port 1 read.
        set_inst(i_type(6'h0D, 5'd0, 5'd1, 16'h8000), 32'h0000_0100, 1'b1);
        #1;
        check("ori.reg1_read", reg1_read_o, 1'b1);
        check("ori.reg2_read", reg2_read_o, 1'b0);
        check("ori.reg2_addr", reg2_addr_o, 5'd0);
        sb.push_back(mk(1'b1, 32'h100, 8'h25, 3'd1, 32'h0, 32'h0000_8000, 5'd1, 1'b1, 1'b0));
        tick("ori");

        // Asynchronous reset mid-stream while stalled: bubble before any edge.
        stall_i = 1'b1;
        #1 rst = 1'b1;
        #1;
        compare_out("midrst", bubble());
        @(posedge clk);
        #1;
        rst = 1'b0; stall_i = 1'b0;

        // ADDU $3,$1,$2 with EX forwarding $1 and MEM forwarding $2.
        set_fwd(1'b1, 5'd1, 32'd5, 1'b0, 1'b1, 5'd2, 32'd7);
        set_inst(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h0000_0104, 1'b1);
        sb.push_back(mk(1'b1, 32'h104, 8'h21, 3'd4, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
        tick("fwd_ex_mem");

        // Both stages write $1: EX wins; $2 falls back to the regfile.
        set_fwd(1'b1, 5'd1, 32'd5, 1'b0, 1'b1, 5'd1, 32'd7);
        reg2_data_i = 32'h22;
        if_pc_i = 32'h0000_0108;
        sb.push_back(mk(1'b1, 32'h108, 8'h21, 3'd4, 32'd5, 32'h22, 5'd3, 1'b1, 1'b0));
        tick("fwd_ex_wins");

        // EX matches but does not write: MEM value is used.
        set_fwd(1'b0, 5'd1, 32'd5, 1'b0, 1'b1, 5'd1, 32'd7);
        if_pc_i = 32'h0000_010C;
        sb.push_back(mk(1'b1, 32'h10C, 8'h21, 3'd4, 32'd7, 32'h22, 5'd3, 1'b1, 1'b0));
        tick("fwd_mem_only");

        // Load-use: LW $4 in EX, ADDU $5,$4,$4 in ID -> one bubble.
        set_fwd(1'b1, 5'd4, 32'hAAAA_AAAA, 1'b1, 1'b0, 5'd0, 32'h0);
        set_inst(r_type(5'd4, 5'd4, 5'd5, 5'd0, 6'h21), 32'h0000_0110, 1'b1);
        #1;
        check("ldu.stallreq", stallreq_o, 1'b1);
        sb.push_back(bubble());
        tick("ldu_bubble");
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd4, 32'd9);
        #1;
        check("ldu.stallreq_clear", stallreq_o, 1'b0);
        sb.push_back(mk(1'b1, 32'h110, 8'h21, 3'd4, 32'd9, 32'd9, 5'd5, 1'b1, 1'b0));
        tick("ldu_resume");

        // Load-use on port 2 only: SUBU $5,$0,$4.
        set_fwd(1'b1, 5'd4, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        set_inst(r_type(5'd0, 5'd4, 5'd5, 5'd0, 6'h23), 32'h0000_0114, 1'b1);
        #1;
        check("ldu2.stallreq", stallreq_o, 1'b1);
        sb.push_back(bubble());
        tick("ldu2_bubble");

        // XOR $6,$1,$2 from the regfile, then hold it through three stall cycles.
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        reg1_data_i = 32'h0F0F; reg2_data_i = 32'h00FF;
        set_inst(r_type(5'd1, 5'd2, 5'd6, 5'd0, 6'h26), 32'h0000_0118, 1'b1);
        sb.push_back(mk(1'b1, 32'h118, 8'h26, 3'd1, 32'h0F0F, 32'h00FF, 5'd6, 1'b1, 1'b0));
        tick("xor");
        stall_i = 1'b1;
        set_inst(r_type(5'd1, 5'd2, 5'd7, 5'd0, 6'h25), 32'h0000_011C, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                set_fwd(1'b1, 5'd1, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
                #1;
                check("stall.stallreq", stallreq_o, 1'b1);
            end else begin
                set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
            end
            sb.push_back(mk(1'b1, 32'h118, 8'h26, 3'd1, 32'h0F0F, 32'h00FF, 5'd6, 1'b1, 1'b0));
            tick($sformatf("stall_hold%0d", i));
        end
        flush_i = 1'b1;
        sb.push_back(bubble());
        tick("flush_and_stall");
        flush_i = 1'b0; stall_i = 1'b0;

        // Reserved opcode 6'h3F.
        set_inst(32'hFFFF_FFFF, 32'h0000_0120, 1'b1);
        #1;
        check("ri.reg1_read", reg1_read_o, 1'b0);
        check("ri.reg2_read", reg2_read_o, 1'b0);
        sb.push_back(mk(1'b1, 32'h120, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
        tick("ri_opcode");

        // Reserved funct under SPECIAL (JR encoding not in the subset).
        set_inst(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h08), 32'h0000_0124, 1'b1);
        sb.push_back(mk(1'b1, 32'h124, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
        tick("ri_funct");

        // ADDU $7,$0,$2 with EX loading $0: never forwarded, no stall.
        set_fwd(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd0, 32'hCAFE_F00D);
        reg1_data_i = 32'h1234;
        set_inst(r_type(5'd0, 5'd2, 5'd7, 5'd0, 6'h21), 32'h0000_0128, 1'b1);
        #1;
        check("zero.stallreq", stallreq_o, 1'b0);
        sb.push_back(mk(1'b1, 32'h128, 8'h21, 3'd4, 32'h0, 32'h00FF, 5'd7, 1'b1, 1'b0));
        tick("zero_reg");

        // SRA $8,$9,5: operand 1 is the shift amount.
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        reg1_data_i = 32'd10; reg2_data_i = 32'h8000_0000;
        set_inst(r_type(5'd0, 5'd9, 5'd8, 5'd5, 6'h03), 32'h0000_012C, 1'b1);
        #1;
        check("sra.reg1_read", reg1_read_o, 1'b0);
        check("sra.reg2_addr", reg2_addr_o, 5'd9);
        sb.push_back(mk(1'b1, 32'h12C, 8'h03, 3'd2, 32'd5, 32'h8000_0000, 5'd8, 1'b1, 1'b0));
        tick("sra");

        // Immediate forms: LUI, ADDIU (sign), ANDI (zero), LW (sign).
        set_inst(i_type(6'h0F, 5'd0, 5'd10, 16'h1234), 32'h0000_0130, 1'b1);
        sb.push_back(mk(1'b1, 32'h130, 8'h25, 3'd1, 32'h0, 32'h1234_0000, 5'd10, 1'b1, 1'b0));
        tick("lui");
        set_inst(i_type(6'h09, 5'd1, 5'd11, 16'hFFFE), 32'h0000_0134, 1'b1);
        sb.push_back(mk(1'b1, 32'h134, 8'h21, 3'd4, 32'd10, 32'hFFFF_FFFE, 5'd11, 1'b1, 1'b0));
        tick("addiu");
        set_inst(i_type(6'h0C, 5'd1, 5'd12, 16'hFFFE), 32'h0000_0138, 1'b1);
        sb.push_back(mk(1'b1, 32'h138, 8'h24, 3'd1, 32'd10, 32'h0000_FFFE, 5'd12, 1'b1, 1'b0));
        tick("andi");
        set_inst(i_type(6'h23, 5'd1, 5'd4, 16'hFFFC), 32'h0000_013C, 1'b1);
        sb.push_back(mk(1'b1, 32'h13C, 8'hE3, 3'd7, 32'd10, 32'hFFFF_FFFC, 5'd4, 1'b1, 1'b0));
        tick("lw");

        // Invalid IF/ID slot with hazard conditions: bubble and no stall request.
        set_fwd(1'b1, 5'd1, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        set_inst(i_type(6'h0D, 5'd1, 5'd2, 16'h0001), 32'h0000_0140, 1'b0);
        #1;
        check("invalid.stallreq", stallreq_o, 1'b0);
        sb.push_back(bubble());
        tick("invalid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS32 pipeline.
- Decodes the IF/ID instruction and drives both regfile read ports (address plus read enable).
- Resolves operands from the regfile data, EX-stage forwarding or MEM-stage forwarding; writeback bypass stays inside the regfile.
- Detects load-use hazards and registers the decoded result into the ID/EX pipeline register that feeds EX.

Parameters:
- RST_PC, 32'h0000_0000, value loaded into ex_pc_o on reset and on bubbles.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stall_i  in  1  global stall from ctrl; hold ID/EX register
- flush_i  in  1  squash; load bubble into ID/EX
- if_pc_i  in  32  PC of instruction in ID
- if_inst_i  in  32  instruction word
- if_valid_i  in  1  instruction word is real (0 = bubble)
- reg1_read_o  out  1  regfile port-1 read enable
- reg1_addr_o  out  5  regfile port-1 address
- reg1_data_i  in  32  regfile port-1 data
- reg2_read_o  out  1  regfile port-2 read enable
- reg2_addr_o  out  5  regfile port-2 address
- reg2_data_i  in  32  regfile port-2 data
- ex_wreg_i  in  1  EX instruction writes a register
- ex_wd_i  in  5  EX destination
- ex_wdata_i  in  32  EX result
- ex_is_load_i  in  1  EX instruction is LW (result not yet available)
- mem_wreg_i  in  1  MEM instruction writes a register
- mem_wd_i  in  5  MEM destination
- mem_wdata_i  in  32  MEM result
- stallreq_o  out  1  load-use stall request to ctrl (combinational)
- ex_valid_o  out  1  registered: ID/EX holds a real instruction
- ex_pc_o  out  32  registered PC
- ex_aluop_o  out  8  registered ALU operation
- ex_alusel_o  out  3  registered result-select class
- ex_reg1_o  out  32  registered operand 1
- ex_reg2_o  out  32  registered operand 2
- ex_wd_o  out  5  registered destination
- ex_wreg_o  out  1  registered write enable
- ex_ri_o  out  1  registered reserved-instruction flag

Behaviour:
- Decoded subset:
  - R-type (op 0): AND, OR, XOR, NOR, ADDU, SUBU, SLT, SLL, SRL, SRA.
  - I-type: ANDI, ORI, XORI, LUI, ADDIU, SLTI, LW, SW.
  - Anything else: ex_ri_o=1, wreg=0, reads disabled, aluop NOP.
- Immediates:
  - ANDI/ORI/XORI: zero-extended.
  - ADDIU/SLTI/LW/SW: sign-extended.
  - LUI: {imm,16'h0}.
  - Shifts: operand1 is the zero-extended 5-bit sa; operand2 is rt.
- Read enables:
  - Asserted only for fields the instruction actually uses.
  - Unused port: address 0, enable 0, operand taken from the immediate or 0.
- Destination: rd for R-type, rt for I-type loads/ALU ops; SW has wreg=0. A write to $0 is passed through as-is; the regfile discards it.
- Operand resolution, per port, in priority order:
  1. Port not read: immediate/0.
  2. Address 0: 0. Never forwarded.
  3. ex_wreg_i and ex_wd_i match: ex_wdata_i.
  4. mem_wreg_i and mem_wd_i match: mem_wdata_i.
  5. Otherwise: regfile data.
- Load-use hazard:
  - stallreq_o=1 when if_valid_i and a read port is enabled with a nonzero address equal to ex_wd_i, with ex_wreg_i and ex_is_load_i both 1.
  - Purely combinational; low during reset.
- ID/EX register update at posedge clk, priority order:
  1. flush_i: load bubble.
  2. stall_i: hold all outputs.
  3. stallreq_o or !if_valid_i: load bubble.
  4. Otherwise: load decoded values.
- Bubble value: valid=0, wreg=0, wd=0, aluop=NOP, alusel=NOP, operands=0, ri=0, pc=RST_PC.
- Reset: rst high asynchronously forces every registered output to its bubble value; pc=RST_PC. Applies mid-stall as well.
- Latency: one cycle from IF/ID to ID/EX. Forwarding adds no cycle; a load-use hazard costs exactly one bubble.
- Simultaneous flush and stall: flush wins.
- Load-use hazard while stall_i is high: hold wins; stallreq_o stays asserted.

Decomposition:
- Shared defines.v (existing include) gains:
  - opcode and funct constants;
  - AluOpBus 8 / AluSelBus 3 widths;
  - EXE_*_OP and EXE_RES_* encodings, with NOP = 0.
- RegBus, RegAddrBus and ZeroWord are reused.
- One sub-module, operand_mux, performs the per-port forwarding selection; it is instantiated twice.

Test Plan:
- Reset: rst=1 mid-stream -> all ex_* outputs zero/bubble and ex_pc_o=RST_PC immediately, without waiting for a clock edge.
- ORI $1,$0,0x8000 -> next cycle: ex_reg1_o=0, ex_reg2_o=32'h0000_8000, ex_wd_o=1, ex_wreg_o=1; reg2_read_o=0.
- ADDU $3,$1,$2 with ex_wd_i=1 (ex_wdata_i=5) and mem_wd_i=2 (mem_wdata_i=7), regfile returning 0 -> ex_reg1_o=5, ex_reg2_o=7. Repeat with ex_wd_i=mem_wd_i=1 -> EX value wins.
- LW $4 in EX (ex_is_load_i=1) and ADDU $5,$4,$4 in ID -> stallreq_o=1; next cycle ex_valid_o=0, ex_wreg_o=0. Then clear ex_is_load_i, set mem_wd_i=4 with mem_wdata_i=9 -> operands both 9.
- stall_i=1 for 3 cycles, then flush_i and stall_i together -> outputs held for the 3 cycles, then a bubble.
- Opcode 6'h3F -> ex_ri_o=1, ex_wreg_o=0. A read of $0 with ex_wd_i=0 and ex_wreg_i=1 -> operand 0.
